// File: rtl/tachyon_pkg.sv
// Shared types and constants for the tachyon SoC data-bus blocks.
// Holds the DMA state encoding, register offsets and CTRL bit positions.
package tachyon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [1:0] DMA_REG_SRC  = 2'd0;
    localparam logic [1:0] DMA_REG_DST  = 2'd1;
    localparam logic [1:0] DMA_REG_LEN  = 2'd2;
    localparam logic [1:0] DMA_REG_CTRL = 2'd3;

    // CTRL write bits
    localparam int CTRL_START  = 0;
    localparam int CTRL_DONE   = 1;
    localparam int CTRL_IRQ_EN = 2;
    // CTRL read bit (DONE and IRQ_EN read back at their write positions)
    localparam int CTRL_BUSY   = 0;

endpackage

// File: rtl/dma_cfg_regs.sv
// DMA configuration register file: SRC/DST/LEN/CTRL, START pulse,
// DONE sticky bit with W1C clear, per-word address stepping and readback.
module dma_cfg_regs
    import tachyon_pkg::*;
#(
    parameter int          LEN_W    = 16,
    parameter logic [31:0] SRC_INCR = 32'd4,
    parameter logic [31:0] DST_INCR = 32'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    input  logic             busy,
    input  logic             step,
    output logic             start,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             done,
    output logic             irq_en,
    output logic [31:0]      rdata
);

    logic ctrl_wr;
    logic clear;
    logic finish;

    assign ctrl_wr = wr && (addr == DMA_REG_CTRL);
    assign start   = ctrl_wr && wdata[CTRL_START];
    assign clear   = ctrl_wr && wdata[CTRL_DONE];

    // A zero-length START completes at once; set wins over a same-write clear.
    assign finish  = (step && (len == LEN_W'(1))) || (start && (len == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            done   <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (wr) begin
                unique case (addr)
                    DMA_REG_SRC:  src    <= wdata;
                    DMA_REG_DST:  dst    <= wdata;
                    DMA_REG_LEN:  len    <= wdata[LEN_W-1:0];
                    DMA_REG_CTRL: irq_en <= wdata[CTRL_IRQ_EN];
                endcase
            end
            if (step) begin
                src <= src + SRC_INCR;
                dst <= dst + DST_INCR;
                len <= len - LEN_W'(1);
            end
            if (finish) begin
                done <= 1'b1;
            end else if (clear) begin
                done <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            DMA_REG_SRC:  rdata = src;
            DMA_REG_DST:  rdata = dst;
            DMA_REG_LEN:  rdata[LEN_W-1:0] = len;
            DMA_REG_CTRL: begin
                rdata[CTRL_BUSY]   = busy;
                rdata[CTRL_DONE]   = done;
                rdata[CTRL_IRQ_EN] = irq_en;
            end
        endcase
    end

endmodule

// File: rtl/bus_dma.sv
// Word-copy DMA engine and CPU/engine data-bus arbiter.
// Optional DMA_VBLANK_SYNC_EN: adds vblank port and ARM state to hold start until vblank.
module bus_dma
    import tachyon_pkg::*;
#(
    parameter int          LEN_W    = 16,
    parameter logic [31:0] SRC_INCR = 32'd4,
    parameter logic [31:0] DST_INCR = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wenable,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        cfg_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wenable,
    input  logic [31:0] bus_rdata,
    output logic        done_irq
`ifdef DMA_VBLANK_SYNC_EN
    ,
    input  logic        vblank
`endif
);

    dma_state_t       state;
    logic             idle;
    logic             cfg_wr;
    logic             start;
    logic             done;
    logic             irq_en;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      cfg_rdata;

    assign idle   = (state == IDLE);
    assign cfg_wr = cfg_sel && (|cpu_wenable) && idle;

    dma_cfg_regs #(
        .LEN_W    (LEN_W),
        .SRC_INCR (SRC_INCR),
        .DST_INCR (DST_INCR)
    ) u_regs (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (cfg_wr),
        .addr   (cpu_addr[3:2]),
        .wdata  (cpu_wdata),
        .busy   (!idle),
        .step   (state == WRITE),
        .start  (start),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .done   (done),
        .irq_en (irq_en),
        .rdata  (cfg_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
`ifdef DMA_VBLANK_SYNC_EN
                        state <= ARM;
`else
                        state <= READ;
`endif
                    end
                end
                ARM: begin
`ifdef DMA_VBLANK_SYNC_EN
                    if (vblank) begin
                        state <= READ;
                    end
`else
                    state <= IDLE;
`endif
                end
                READ: begin
                    state <= WRITE;
                end
                WRITE: begin
                    state <= (len == LEN_W'(1)) ? IDLE : READ;
                end
            endcase
        end
    end

    // Engine owns the bus whenever not idle; writes are blocked while in reset.
    always_comb begin
        bus_addr    = cpu_addr;
        bus_wdata   = cpu_wdata;
        bus_wenable = cfg_sel ? 4'h0 : cpu_wenable;
        unique case (state)
            IDLE: begin
            end
            ARM, READ: begin
                bus_addr    = src;
                bus_wdata   = '0;
                bus_wenable = 4'h0;
            end
            WRITE: begin
                bus_addr    = dst;
                bus_wdata   = bus_rdata;
                bus_wenable = 4'hF;
            end
        endcase
        if (!rst_n) begin
            bus_wenable = 4'h0;
        end
    end

    assign cpu_stall = !idle;
    assign cpu_rdata = cfg_sel ? cfg_rdata : bus_rdata;
    assign done_irq  = done && irq_en;

endmodule

// File: tb/tb_bus_dma.sv
// Randomized bench for bus_dma: copy (SRC_INCR=4) and fill (SRC_INCR=0) instances
// checked every cycle against a transfer-level model with its own memory image.
module tb_bus_dma;

    localparam int LEN_W = 16;
`ifdef DMA_VBLANK_SYNC_EN
    localparam int ARMC = 1;
`else
    localparam int ARMC = 0;
`endif

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] w;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0][31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0][3:0]  cpu_wenable, bus_wenable;
    logic [1:0]       cpu_stall, cfg_sel, done_irq;
`ifdef DMA_VBLANK_SYNC_EN
    logic vblank = 1'b1;
`endif

    logic        init_req = 1'b0;
    int unsigned epoch = 0;
    logic [31:0] bmem [2][1024];
    logic [31:0] mmem [2][1024];

    logic [31:0]      m_src [2];
    logic [31:0]      m_dst [2];
    logic [LEN_W-1:0] m_len [2];
    bit               m_done[2];
    bit               m_irq [2];
    bit               m_arm [2];
    int               m_left[2];
    xfer_t            xq [2][64];
    int               hd [2];
    int               tl [2];

    int vectors = 0;
    int miscompares = 0;

    bus_dma #(.LEN_W(LEN_W), .SRC_INCR(32'd4), .DST_INCR(32'd4)) u_copy (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_wenable(cpu_wenable[0]),
        .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]), .cfg_sel(cfg_sel[0]),
        .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]), .bus_wenable(bus_wenable[0]),
        .bus_rdata(bus_rdata[0]), .done_irq(done_irq[0])
`ifdef DMA_VBLANK_SYNC_EN
        , .vblank(vblank)
`endif
    );

    bus_dma #(.LEN_W(LEN_W), .SRC_INCR(32'd0), .DST_INCR(32'd4)) u_fill (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_wenable(cpu_wenable[1]),
        .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]), .cfg_sel(cfg_sel[1]),
        .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]), .bus_wenable(bus_wenable[1]),
        .bus_rdata(bus_rdata[1]), .done_irq(done_irq[1])
`ifdef DMA_VBLANK_SYNC_EN
        , .vblank(vblank)
`endif
    );

    function automatic logic [31:0] init_val(int unsigned e, int k, int i);
        return (32'(i) * 32'h9E37_79B1) ^ (e * 32'h85EB_CA6B) ^ (32'(k) << 28);
    endfunction

    // 4 KB aliasing memory behind the decoder, 1-cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init_req) begin
                for (int i = 0; i < 1024; i++) bmem[k][i] <= init_val(epoch, k, i);
            end else begin
                bus_rdata[k] <= bmem[k][bus_addr[k][11:2]];
                for (int b = 0; b < 4; b++)
                    if (bus_wenable[k][b])
                        bmem[k][bus_addr[k][11:2]][8*b +: 8] <= bus_wdata[k][8*b +: 8];
            end
        end
    end

    task automatic chk(bit ok, string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            if (miscompares <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole transfer computed up front, word by word in order
    task automatic launch(int k);
        logic [31:0] si;
        xfer_t x;
        si = (k == 0) ? 32'd4 : 32'd0;
        hd[k] = 0;
        tl[k] = 0;
        for (int i = 0; i < int'(m_len[k]); i++) begin
            x.s = m_src[k] + 32'(i) * si;
            x.d = m_dst[k] + 32'(i) * 32'd4;
            x.w = mmem[k][x.s[11:2]];
            mmem[k][x.d[11:2]] = x.w;
            xq[k][tl[k]] = x;
            tl[k]++;
        end
        m_src[k] = m_src[k] + 32'(m_len[k]) * si;
        m_dst[k] = m_dst[k] + 32'(m_len[k]) * 32'd4;
        m_left[k] = 2 * int'(m_len[k]);
        m_len[k] = '0;
        m_arm[k] = (ARMC != 0);
    endtask

    task automatic step(int k);
        bit busy;
        logic [31:0] exp_r, w;
        logic [3:0] exp_we;
        xfer_t x;
        if (init_req)
            for (int i = 0; i < 1024; i++) mmem[k][i] = init_val(epoch, k, i);
        if (!rst_n) begin
            chk(bus_wenable[k] === 4'h0, "rst_wen", 32'(bus_wenable[k]), 0);
            m_src[k] = '0; m_dst[k] = '0; m_len[k] = '0;
            m_done[k] = 0; m_irq[k] = 0; m_arm[k] = 0; m_left[k] = 0;
            hd[k] = 0; tl[k] = 0;
            return;
        end
        busy = m_arm[k] || (m_left[k] > 0);
        chk(cpu_stall[k] === busy, "stall", 32'(cpu_stall[k]), 32'(busy));
        chk(done_irq[k] === (m_done[k] & m_irq[k]), "done_irq",
            32'(done_irq[k]), 32'(m_done[k] & m_irq[k]));
        if (!busy) begin
            exp_we = cfg_sel[k] ? 4'h0 : cpu_wenable[k];
            chk(bus_addr[k] === cpu_addr[k], "pass_addr", bus_addr[k], cpu_addr[k]);
            chk(bus_wdata[k] === cpu_wdata[k], "pass_wdata", bus_wdata[k], cpu_wdata[k]);
            chk(bus_wenable[k] === exp_we, "pass_wen", 32'(bus_wenable[k]), 32'(exp_we));
            w = cpu_wdata[k];
            if (cfg_sel[k]) begin
                case (cpu_addr[k][3:2])
                    2'd0:    exp_r = m_src[k];
                    2'd1:    exp_r = m_dst[k];
                    2'd2:    exp_r = 32'(m_len[k]);
                    default: exp_r = {29'b0, m_irq[k], m_done[k], 1'b0};
                endcase
                chk(cpu_rdata[k] === exp_r, "cfg_read", cpu_rdata[k], exp_r);
                if (|cpu_wenable[k]) begin
                    case (cpu_addr[k][3:2])
                        2'd0: m_src[k] = w;
                        2'd1: m_dst[k] = w;
                        2'd2: m_len[k] = w[LEN_W-1:0];
                        default: begin
                            m_irq[k] = w[2];
                            if (w[1]) m_done[k] = 0;
                            if (w[0]) begin
                                if (m_len[k] == 0) m_done[k] = 1;
                                else launch(k);
                            end
                        end
                    endcase
                end
            end else begin
                chk(cpu_rdata[k] === bus_rdata[k], "cpu_rdata", cpu_rdata[k], bus_rdata[k]);
                for (int b = 0; b < 4; b++)
                    if (cpu_wenable[k][b]) mmem[k][cpu_addr[k][11:2]][8*b +: 8] = w[8*b +: 8];
            end
        end else if (m_arm[k]) begin
            chk(bus_wenable[k] === 4'h0, "arm_wen", 32'(bus_wenable[k]), 0);
`ifdef DMA_VBLANK_SYNC_EN
            if (vblank) m_arm[k] = 0;
`endif
        end else begin
            x = xq[k][hd[k]];
            if (m_left[k] % 2 == 0) begin
                chk(bus_wenable[k] === 4'h0, "rd_wen", 32'(bus_wenable[k]), 0);
                chk(bus_addr[k] === x.s, "rd_addr", bus_addr[k], x.s);
            end else begin
                chk(bus_wenable[k] === 4'hF, "wr_wen", 32'(bus_wenable[k]), 32'hF);
                chk(bus_addr[k] === x.d, "wr_addr", bus_addr[k], x.d);
                chk(bus_wdata[k] === x.w, "wr_data", bus_wdata[k], x.w);
                hd[k]++;
            end
            m_left[k]--;
            if (m_left[k] == 0) m_done[k] = 1;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) step(k);
    end

    task automatic cyc(int k, bit sel, logic [31:0] a, logic [31:0] d, logic [3:0] we);
        @(posedge clk);
        #1;
        cfg_sel[k] = sel;
        cpu_addr[k] = a;
        cpu_wdata[k] = d;
        cpu_wenable[k] = we;
    endtask

    task automatic idle(int k);
        cyc(k, 1'b0, $urandom, $urandom, 4'h0);
    endtask

    task automatic cfg_wr(int k, logic [1:0] r, logic [31:0] d);
        cyc(k, 1'b1, {28'h0, r, 2'b00}, d, 4'($urandom_range(1, 15)));
    endtask

    task automatic cfg_rd(int k, logic [1:0] r, logic [31:0] exp, string nm);
        cyc(k, 1'b1, {28'h0, r, 2'b00}, 32'h0, 4'h0);
        @(negedge clk);
        chk(cpu_rdata[k] === exp, nm, cpu_rdata[k], exp);
    endtask

    task automatic wait_done(int k, output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            idle(k);
            @(negedge clk);
            if (cpu_stall[k]) n++;
            else if (n > 0 || i >= 2) return;
        end
        chk(1'b0, "timeout", 32'(n), 0);
    endtask

    task automatic reinit();
        epoch++;
        @(posedge clk);
        #1 init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
    endtask

    task automatic rnd_traffic(int k);
        bit sel;
        logic [31:0] a;
        logic [3:0] we;
        sel = 1'($urandom_range(0, 1));
        a = $urandom;
        we = 4'($urandom);
        if (sel && we != 0) a[3] = 1'b0;
        cyc(k, sel, a, $urandom, we);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int k;
        logic [LEN_W-1:0] len;
        logic [31:0] ctl;
        cfg_sel = '0; cpu_addr = '0; cpu_wdata = '0; cpu_wenable = '0;
        reinit();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < 2; j++) begin
                cfg_sel[j] = 1'b0;
                cpu_addr[j] = $urandom;
                cpu_wdata[j] = $urandom;
                cpu_wenable[j] = 4'hF;
            end
            @(negedge clk);
            if (c == 1) begin
                chk(cpu_stall[0] === 1'b0, "rst_stall", 32'(cpu_stall[0]), 0);
                chk(done_irq[0] === 1'b0, "rst_irq", 32'(done_irq[0]), 0);
                chk(bus_addr[0] === cpu_addr[0], "rst_pass", bus_addr[0], cpu_addr[0]);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0); idle(1);
        cfg_rd(0, 2'd0, 32'h0, "rst_src");
        cfg_rd(0, 2'd2, 32'h0, "rst_len");
        cfg_rd(1, 2'd3, 32'h0, "rst_ctrl");

        // three-word copy
        cyc(0, 1'b0, 32'h100, 32'h1111_0100, 4'hF);
        cyc(0, 1'b0, 32'h104, 32'h1111_0104, 4'hF);
        cyc(0, 1'b0, 32'h108, 32'h1111_0108, 4'hF);
        cfg_wr(0, 2'd0, 32'h0000_0100);
        cfg_wr(0, 2'd1, 32'h4000_0000);
        cfg_wr(0, 2'd2, 32'd3);
        cfg_wr(0, 2'd3, 32'h1);
        wait_done(0, n);
        chk(n == 6 + ARMC, "copy_stall", 32'(n), 32'(6 + ARMC));
        cfg_rd(0, 2'd3, 32'h2, "copy_ctrl");
        cfg_rd(0, 2'd1, 32'h4000_000C, "copy_dst");
        cfg_rd(0, 2'd0, 32'h0000_010C, "copy_src");
        chk(bmem[0][0] === 32'h1111_0100, "copy_w0", bmem[0][0], 32'h1111_0100);
        chk(bmem[0][2] === 32'h1111_0108, "copy_w2", bmem[0][2], 32'h1111_0108);

        // zero length: DONE one cycle later, no bus cycle
        cfg_wr(0, 2'd3, 32'h2);
        cfg_wr(0, 2'd2, 32'd0);
        cfg_rd(0, 2'd3, 32'h0, "len0_pre");
        cfg_wr(0, 2'd3, 32'h1);
        cfg_rd(0, 2'd3, 32'h2, "len0_done");
        repeat (3) idle(0);

        // fill
        cyc(1, 1'b0, 32'h200, 32'hA5A5_A5A5, 4'hF);
        cfg_wr(1, 2'd0, 32'h0000_0200);
        cfg_wr(1, 2'd1, 32'h8000_0000);
        cfg_wr(1, 2'd2, 32'd16);
        cfg_wr(1, 2'd3, 32'h1);
        wait_done(1, n);
        chk(n == 32 + ARMC, "fill_stall", 32'(n), 32'(32 + ARMC));
        cfg_rd(1, 2'd1, 32'h8000_0040, "fill_dst");
        cfg_rd(1, 2'd0, 32'h0000_0200, "fill_src");
        chk(bmem[1][15] === 32'hA5A5_A5A5, "fill_w15", bmem[1][15], 32'hA5A5_A5A5);

        // address wrap
        cfg_wr(0, 2'd0, 32'hFFFF_FFF8);
        cfg_wr(0, 2'd1, 32'hFFFF_FFFC);
        cfg_wr(0, 2'd2, 32'd4);
        cfg_wr(0, 2'd3, 32'h3);
        wait_done(0, n);
        cfg_rd(0, 2'd0, 32'h0000_0008, "wrap_src");
        cfg_rd(0, 2'd1, 32'h0000_000C, "wrap_dst");

        // interrupt
        cfg_wr(0, 2'd3, 32'h2);
        cfg_wr(0, 2'd3, 32'h4);
        cfg_wr(0, 2'd2, 32'd1);
        cfg_wr(0, 2'd3, 32'h5);
        wait_done(0, n);
        chk(done_irq[0] === 1'b1, "irq_hi", 32'(done_irq[0]), 1);
        cfg_wr(0, 2'd3, 32'h6);
        idle(0);
        @(negedge clk);
        chk(done_irq[0] === 1'b0, "irq_lo", 32'(done_irq[0]), 0);

        // random transfers with CPU traffic between them
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 1);
            repeat ($urandom_range(0, 3)) rnd_traffic(k);
            len = LEN_W'($urandom_range(0, 12));
            ctl = {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
            cfg_wr(k, 2'd0, $urandom);
            cfg_wr(k, 2'd1, $urandom);
            cfg_wr(k, 2'd2, 32'(len));
            cfg_wr(k, 2'd3, ctl);
            wait_done(k, n);
            chk(n == ((len != 0) ? 2 * int'(len) + ARMC : 0), "rnd_stall",
                32'(n), 32'((len != 0) ? 2 * int'(len) + ARMC : 0));
        end

        // reset in the middle of a transfer
        cfg_wr(0, 2'd2, 32'd8);
        cfg_wr(0, 2'd3, 32'h1);
        repeat (5) idle(0);
        pulse_reset();
        reinit();
        cfg_rd(0, 2'd0, 32'h0, "midrst_src");
        cfg_rd(0, 2'd3, 32'h0, "midrst_ctrl");

`ifdef DMA_VBLANK_SYNC_EN
        @(posedge clk);
        #1 vblank = 1'b0;
        cfg_wr(0, 2'd2, 32'd2);
        cfg_wr(0, 2'd3, 32'h1);
        for (int i = 0; i < 10; i++) begin
            idle(0);
            @(negedge clk);
            chk(cpu_stall[0] === 1'b1, "arm_hold", 32'(cpu_stall[0]), 1);
        end
        @(posedge clk);
        #1 vblank = 1'b1;
        wait_done(0, n);
        cfg_rd(0, 2'd3, 32'h2, "arm_ctrl");
        @(posedge clk);
        #1 vblank = 1'b0;
        cfg_wr(0, 2'd2, 32'd3);
        cfg_wr(0, 2'd3, 32'h3);
        repeat (3) idle(0);
        pulse_reset();
        @(posedge clk);
        #1 vblank = 1'b1;
        repeat (5) idle(0);
        cfg_rd(0, 2'd3, 32'h0, "armrst_ctrl");
        reinit();
`endif

        repeat (3) idle(0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
